// File: rtl/intr_pkg.sv
// Shared definitions for the interrupt entry/return sequencer: state encoding,
// parameter defaults and the line priority function.
package intr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ENTRY,
    VECTOR
  } state_t;

  localparam int          DEF_PC_WIDTH    = 10;
  localparam int          DEF_STACK_DEPTH = 4;
  localparam logic [9:0]  DEF_VECTOR_BASE = 10'h3C0;

  // Line 0 has the highest priority, so the lowest set bit wins.
  function automatic logic [2:0] lowest_set_index(input logic [7:0] lines);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (lines[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/intr_stack.sv
// LIFO of {line index, return PC} frames for nested interrupt service.
// The frame storage is deliberately not reset; only the fill count is.
module intr_stack #(
  parameter int PC_WIDTH    = 10,
  parameter int STACK_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic                pop,
  input  logic [2:0]          push_index,
  input  logic [PC_WIDTH-1:0] push_pc,
  output logic [2:0]          top_index,
  output logic [PC_WIDTH-1:0] top_pc,
  output logic [2:0]          count,
  output logic                full,
  output logic                empty
);

  localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [2:0]          index_mem [STACK_DEPTH];
  logic [PC_WIDTH-1:0] pc_mem    [STACK_DEPTH];
  logic [AW-1:0]       top_ptr;
  logic [AW-1:0]       wr_ptr;

  assign full      = (count == 3'(STACK_DEPTH));
  assign empty     = (count == 3'd0);
  assign top_ptr   = AW'(count - 3'd1);
  assign wr_ptr    = AW'(count);
  assign top_index = index_mem[top_ptr];
  assign top_pc    = pc_mem[top_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 3'd0;
    end else if (push && !full) begin
      count <= count + 3'd1;
    end else if (pop && !empty) begin
      count <= count - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      index_mem[wr_ptr] <= push_index;
      pc_mem[wr_ptr]    <= push_pc;
    end
  end

endmodule

// File: rtl/intr_sequencer.sv
// Interrupt entry/return sequencer: freezes fetch, saves the return PC,
// loads the line's vector, and restores the PC on return-from-interrupt.
module intr_sequencer
  import intr_pkg::*;
#(
  parameter int                  PC_WIDTH    = DEF_PC_WIDTH,
  parameter int                  STACK_DEPTH = DEF_STACK_DEPTH,
  parameter logic [PC_WIDTH-1:0] VECTOR_BASE = PC_WIDTH'(DEF_VECTOR_BASE)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s_stop_opcode,
  input  logic [7:0]          interrupt_out,
  input  logic                opcode_reti,
  input  logic [PC_WIDTH-1:0] pc_in,
  output logic                fetch_hold,
  output logic                pc_load,
  output logic [PC_WIDTH-1:0] pc_next,
  output logic                s_return_intr,
  output logic [7:0]          in_service,
  output logic [2:0]          depth,
  output logic                nest_overflow,
  output logic                reti_underflow
);

  state_t     state;
  logic [2:0] sel_index;
  logic [7:0] pending;
  logic       is_new;
  logic       push;
  logic       pop;
  logic [2:0] top_index;
  logic [PC_WIDTH-1:0] top_pc;
  logic       full;
  logic       empty;

  assign pending = interrupt_out & ~in_service;
  assign is_new  = s_stop_opcode && (pending != 8'h00);
  assign push    = (state == ENTRY);
  assign pop     = (state == IDLE) && opcode_reti && !empty;

  intr_stack #(
    .PC_WIDTH    (PC_WIDTH),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .push_index (sel_index),
    .push_pc    (pc_in),
    .top_index  (top_index),
    .top_pc     (top_pc),
    .count      (depth),
    .full       (full),
    .empty      (empty)
  );

  // A return always wins over a new request; the manager keeps the request
  // asserted, so it is picked up on a later IDLE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      sel_index      <= 3'd0;
      fetch_hold     <= 1'b0;
      pc_load        <= 1'b0;
      pc_next        <= '0;
      s_return_intr  <= 1'b0;
      in_service     <= 8'h00;
      nest_overflow  <= 1'b0;
      reti_underflow <= 1'b0;
    end else begin
      pc_load       <= 1'b0;
      s_return_intr <= 1'b0;
      case (state)
        IDLE: begin
          fetch_hold <= 1'b0;
          if (opcode_reti) begin
            if (!empty) begin
              pc_next               <= top_pc;
              pc_load               <= 1'b1;
              s_return_intr         <= 1'b1;
              in_service[top_index] <= 1'b0;
            end else begin
              reti_underflow <= 1'b1;
            end
          end else if (is_new) begin
            if (full) begin
              nest_overflow <= 1'b1;
            end else begin
              sel_index  <= lowest_set_index(pending);
              fetch_hold <= 1'b1;
              state      <= ENTRY;
            end
          end
        end
        ENTRY: begin
          in_service[sel_index] <= 1'b1;
          fetch_hold            <= 1'b1;
          state                 <= VECTOR;
        end
        VECTOR: begin
          // Wraps naturally at PC_WIDTH bits.
          pc_next    <= VECTOR_BASE + PC_WIDTH'({sel_index, 2'b00});
          pc_load    <= 1'b1;
          fetch_hold <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          fetch_hold <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/intr_sequencer.md
INTR_SEQUENCER -- requirements
Module: intr_sequencer

Interface
REQ-001 The block SHALL have the parameter PC_WIDTH, default 10, meaning the program counter width in bits.
REQ-002 The block SHALL have the parameter STACK_DEPTH, default 4, meaning the maximum number of nested interrupts.
REQ-003 The block SHALL have the parameter VECTOR_BASE, default 10'h3C0, meaning the address of the vector for line 0.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset; its ports SHALL be clk and reset.
REQ-005 Port: clk  in  1  system clock; all state changes on its rising edge.
REQ-006 Port: reset  in  1  synchronous, active-high reset.
REQ-007 Port: s_stop_opcode  in  1  the interrupt manager requests suspension of instruction fetch.
REQ-008 Port: interrupt_out  in  8  lines currently granted by the interrupt manager.
REQ-009 Port: opcode_reti  in  1  the decoder has executed a return-from-interrupt instruction; one-cycle pulse.
REQ-010 Port: pc_in  in  PC_WIDTH  the address of the next instruction to execute.
REQ-011 Port: fetch_hold  out  1  freezes fetch and decode while asserted.
REQ-012 Port: pc_load  out  1  the PC SHALL load pc_next on the next clock edge.
REQ-013 Port: pc_next  out  PC_WIDTH  the PC value to load: the vector on entry, the saved address on return.
REQ-014 Port: s_return_intr  out  1  one-cycle pulse telling the manager that service has ended.
REQ-015 Port: in_service  out  8  mask of lines currently being serviced.
REQ-016 Port: depth  out  3  number of stack entries in use.
REQ-017 Port: nest_overflow  out  1  sticky error: an interrupt was refused because the stack was full.
REQ-018 Port: reti_underflow  out  1  sticky error: opcode_reti arrived while the stack was empty.

Function
REQ-019 The state machine SHALL have the states IDLE, ENTRY and VECTOR, and all outputs SHALL be registered.
REQ-020 An interrupt is "new" when s_stop_opcode=1 and (interrupt_out & ~in_service) != 0.
REQ-021 The selected index SHALL be the lowest set bit of (interrupt_out & ~in_service).
REQ-022 On a new interrupt in IDLE with depth < STACK_DEPTH, the block SHALL go to ENTRY.
REQ-023 In ENTRY, the block SHALL push {index, pc_in}, set in_service[index], assert fetch_hold, and go to VECTOR.
REQ-024 In VECTOR, the block SHALL assert pc_load=1 and fetch_hold=1, drive pc_next = VECTOR_BASE + 4*index, then go to IDLE.
REQ-025 Entry latency SHALL be exactly 2 cycles from detection to the pc_load pulse.
REQ-026 When opcode_reti=1 in IDLE and depth > 0, the block SHALL, in the same cycle:
  - pop the stack;
  - drive pc_next = the saved PC and pulse pc_load;
  - pulse s_return_intr;
  - clear in_service[saved index].
REQ-027 When opcode_reti=1 and depth=0, the block SHALL take no action other than setting reti_underflow.
REQ-028 When opcode_reti and a new interrupt occur in the same IDLE cycle, the return SHALL take precedence; the interrupt SHALL be taken on a later cycle, since the manager holds it.
REQ-029 A new interrupt with depth = STACK_DEPTH SHALL cause no push and no fetch_hold, and SHALL set nest_overflow.
REQ-030 opcode_reti received in ENTRY or VECTOR SHALL be ignored.
REQ-031 Vector arithmetic SHALL be computed modulo 2^PC_WIDTH.
REQ-032 Nesting SHALL be allowed: a new line not in in_service is accepted while other lines are in service.

Reset
REQ-033 Reset SHALL put the block in IDLE with depth=0, in_service=0 and all outputs 0, including both sticky flags.
REQ-034 Reset asserted during ENTRY or VECTOR SHALL abort the sequence with no pc_load.
REQ-035 Stack contents need not be cleared on reset.

Structure
REQ-036 Package intr_pkg SHALL hold the state encoding, the PC_WIDTH/STACK_DEPTH/VECTOR_BASE defaults and the lowest-set-bit index function.
REQ-037 The stack SHALL be implemented as the sub-module intr_stack, a LIFO of {3-bit index, PC} entries with push, pop, full and empty signals.

Verification
REQ-038 Scenario: s_stop_opcode=1, interrupt_out=8'h04, pc_in=10'h025 -> 2 cycles later pc_load=1, pc_next=10'h3C8, in_service=8'h04, depth=1.
REQ-039 Scenario: from that state, opcode_reti pulse -> pc_next=10'h025, pc_load=1, one-cycle s_return_intr, in_service=0, depth=0.
REQ-040 Scenario: nesting with lines 2 then 0 (interrupt_out=8'h05) -> second vector 10'h3C0, depth=2; two RETIs restore the PCs in LIFO order.
REQ-041 Scenario: 5 distinct lines taken without RETI -> the fifth is refused, nest_overflow=1, depth stays 4, no fetch_hold.
REQ-042 Scenario: RETI at depth=0 -> reti_underflow=1 and no pc_load; simultaneous RETI and a new interrupt -> return first, entry begins the following cycle.
REQ-043 Scenario: reset asserted in the VECTOR cycle -> no pc_load, all outputs 0 on the next cycle.
